// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared state types and frame geometry for the UART word link.
package uart_link_pkg;
    typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_HOLD} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    localparam int FRAME_BYTES   = 5;
    localparam int PAYLOAD_BYTES = 4;
endpackage

// File: rtl/uart_word_link.sv
// uart_word_link: frames 5-byte UART commands into one command word and
// serializes 32-bit responses into 5-byte UART frames.
module uart_word_link
    import uart_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter logic [3:0]  CMD_SYNC       = 4'hA,
    parameter logic [7:0]  RESP_SYNC      = 8'h5A
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        UART_RX_EMPTY_I,
    output logic        UART_RE_O,
    input  logic [7:0]  UART_DREC_I,
    input  logic        UART_TX_READY_I,
    output logic        UART_WE_O,
    output logic [7:0]  UART_DSEND_O,
    output logic        CMD_VALID_O,
    input  logic        CMD_READY_I,
    output logic [3:0]  CMD_O,
    output logic [31:0] DATA_O,
    input  logic        RESP_VALID_I,
    output logic        RESP_READY_O,
    input  logic [31:0] RESP_DATA_I,
    output logic        FRAME_ERR_O
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    rx_state_e rx_q, rx_d;
    tx_state_e tx_q, tx_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [31:0]   data_q, data_d, rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [2:0]    idx_q, idx_d, bsel;
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            rx_q   <= RX_HDR;
            bcnt_q <= '0;
            cnt_q  <= '0;
            cmd_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rx_q   <= rx_d;
            bcnt_q <= bcnt_d;
            cnt_q  <= cnt_d;
            cmd_q  <= cmd_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end
    // Inter-byte counter only advances while waiting for payload; any pop restarts it.
    always_comb begin
        rx_d      = rx_q;
        bcnt_d    = bcnt_q;
        cnt_d     = '0;
        cmd_d     = cmd_q;
        data_d    = data_q;
        err_d     = 1'b0;
        UART_RE_O = 1'b0;
        unique case (rx_q)
            RX_HDR: begin
                UART_RE_O = ~UART_RX_EMPTY_I;
                if (UART_RE_O) begin
                    if (UART_DREC_I[7:4] == CMD_SYNC) begin
                        cmd_d  = UART_DREC_I[3:0];
                        bcnt_d = '0;
                        rx_d   = RX_PAY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RX_PAY: begin
                UART_RE_O = ~UART_RX_EMPTY_I;
                if (UART_RE_O) begin
                    data_d[8*bcnt_q +: 8] = UART_DREC_I;
                    bcnt_d = bcnt_q + 2'd1;
                    rx_d   = (bcnt_q == 2'(PAYLOAD_BYTES - 1)) ? RX_HOLD : RX_PAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    err_d = (cnt_d == TO_LAST);
                    rx_d  = err_d ? RX_HDR : RX_PAY;
                end
            end
            RX_HOLD: rx_d = CMD_READY_I ? RX_HDR : RX_HOLD;
            default: rx_d = RX_HDR;
        endcase
    end
    assign CMD_VALID_O = (rx_q == RX_HOLD);
    assign CMD_O       = cmd_q;
    assign DATA_O      = data_q;
    assign FRAME_ERR_O = err_q;
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            tx_q    <= TX_IDLE;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            tx_q    <= tx_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        tx_d      = tx_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        UART_WE_O = 1'b0;
        unique case (tx_q)
            TX_IDLE: begin
                if (RESP_VALID_I) begin
                    rdata_d = RESP_DATA_I;
                    idx_d   = '0;
                    tx_d    = TX_SEND;
                end
            end
            TX_SEND: begin
                UART_WE_O = UART_TX_READY_I;
                if (UART_WE_O) begin
                    idx_d = idx_q + 3'd1;
                    tx_d  = (idx_q == 3'(FRAME_BYTES - 1)) ? TX_IDLE : TX_SEND;
                end
            end
            default: tx_d = TX_IDLE;
        endcase
    end
    assign bsel         = idx_q - 3'd1;
    assign RESP_READY_O = (tx_q == TX_IDLE);
    assign UART_DSEND_O = (tx_q != TX_SEND) ? 8'h00 :
                          (idx_q == 3'd0)   ? RESP_SYNC : rdata_q[{bsel[1:0], 3'b000} +: 8];
endmodule

// File: tb/tb_uart_word_link.sv
// tb_uart_word_link: directed checks of RX framing, timeout, TX serialization and async reset.
module tb_uart_word_link;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        empty = 1'b1, re, tx_ready = 1'b0, we, cmd_valid, cmd_ready = 1'b0;
    logic        resp_valid = 1'b0, resp_ready, err;
    logic [7:0]  drec = '0, dsend;
    logic [3:0]  cmd;
    logic [31:0] data, resp_data = '0;
    logic [7:0]  exp_tx [5];
    logic [15:0] pat;
    int          total = 0, bad = 0, nb;
    always #5 clk = ~clk;
    uart_word_link #(.TIMEOUT_CYCLES(16)) dut (
        .CLK_I(clk), .RST_NI(rst_n),
        .UART_RX_EMPTY_I(empty), .UART_RE_O(re), .UART_DREC_I(drec),
        .UART_TX_READY_I(tx_ready), .UART_WE_O(we), .UART_DSEND_O(dsend),
        .CMD_VALID_O(cmd_valid), .CMD_READY_I(cmd_ready), .CMD_O(cmd), .DATA_O(data),
        .RESP_VALID_I(resp_valid), .RESP_READY_O(resp_ready), .RESP_DATA_I(resp_data),
        .FRAME_ERR_O(err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic rx_byte(input logic [7:0] b);
        empty = 1'b0;
        drec  = b;
        @(negedge clk);
        chk("rx_re", re, 1);
        @(posedge clk); #1;
        empty = 1'b1;
    endtask
    task automatic accept_cmd();
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("cmd_released", cmd_valid, 0);
    endtask
    task automatic send_resp(input logic [31:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        chk("resp_busy", resp_ready, 0);
    endtask
    task automatic tx_burst(input logic [31:0] d);
        exp_tx = '{8'h5A, d[7:0], d[15:8], d[23:16], d[31:24]};
        tx_ready = 1'b1;
        send_resp(d);
        for (int i = 0; i < 5; i++) begin
            chk("tx_we", we, 1);
            chk("tx_byte", dsend, exp_tx[i]);
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        chk("tx_ready_again", resp_ready, 1);
        chk("tx_we_idle", we, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_resp_ready", resp_ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_err", err, 0);
        chk("rst_dsend", dsend, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // 1: basic frame and hold
        rx_byte(8'hA3); rx_byte(8'h78); rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
        chk("t1_valid", cmd_valid, 1);
        chk("t1_cmd", cmd, 4'h3);
        chk("t1_data", data, 32'h12345678);
        empty = 1'b0;
        drec  = 8'hA9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_hold_re", re, 0);
            chk("t1_hold_valid", cmd_valid, 1);
            chk("t1_hold_data", data, 32'h12345678);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        empty = 1'b1;
        chk("t1_released", cmd_valid, 0);
        // 2: bad header then good frame
        rx_byte(8'h33);
        chk("t2_err", err, 1);
        rx_byte(8'hA1);
        chk("t2_err_once", err, 0);
        rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h00);
        chk("t2_valid", cmd_valid, 1);
        chk("t2_cmd", cmd, 4'h1);
        chk("t2_data", data, 32'h00000001);
        chk("t2_no_err", err, 0);
        accept_cmd();
        // 3: inter-byte timeout
        rx_byte(8'hA2); rx_byte(8'h11);
        for (int k = 0; k <= 20; k++) begin
            chk("t3_timeout_err", err, (k == 15) ? 1 : 0);
            @(posedge clk); #1;
        end
        chk("t3_no_valid", cmd_valid, 0);
        chk("t3_data_kept", data, 32'h00000011);
        rx_byte(8'hA4); rx_byte(8'h44); rx_byte(8'h33); rx_byte(8'h22); rx_byte(8'h11);
        chk("t3_cmd", cmd, 4'h4);
        chk("t3_data", data, 32'h11223344);
        accept_cmd();
        // 4: back-to-back response
        tx_burst(32'hDEADBEEF);
        // 5: stalling response
        exp_tx = '{8'h5A, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pat = 16'b0000_1110_0101_1001;
        nb  = 0;
        send_resp(32'hDEADBEEF);
        for (int j = 0; j < 16; j++) begin
            tx_ready = pat[j];
            @(negedge clk);
            chk("t5_we", we, (pat[j] && nb < 5) ? 1 : 0);
            if (we && nb < 5) begin
                chk("t5_byte", dsend, exp_tx[nb]);
                nb++;
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        chk("t5_count", nb, 5);
        chk("t5_idle", resp_ready, 1);
        // 6: async reset mid-payload and mid-TX
        send_resp(32'h55667788);
        rx_byte(8'hA5); rx_byte(8'h01);
        tx_ready = 1'b1;
        #1;
        chk("t6_pre_we", we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_we", we, 0);
        chk("t6_rst_resp_ready", resp_ready, 1);
        chk("t6_rst_dsend", dsend, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_cmd", cmd, 0);
        chk("t6_rst_valid", cmd_valid, 0);
        tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rx_byte(8'hA6); rx_byte(8'h0D); rx_byte(8'h0C); rx_byte(8'h0B); rx_byte(8'h0A);
        chk("t6_valid", cmd_valid, 1);
        chk("t6_cmd", cmd, 4'h6);
        chk("t6_data", data, 32'h0A0B0C0D);
        accept_cmd();
        tx_burst(32'h01020304);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
